// File: rtl/mtimer_responder.sv
// Memory-mapped machine timer (mtime/mtimecmp, prescaler, level interrupt) on the CPU data bus.
// Optional MTIMER_SNAPSHOT_EN: loads of MTIME_LO latch mtime[63:32] so MTIME_HI reads are atomic.
module mtimer_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_8000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dmem_rw_addr,
  input  logic [31:0] dmem_w_data,
  input  logic        dmem_w_en,
  input  logic        dmem_r_en,
  input  logic [2:0]  funct3,
  output logic        hit,
  output logic [31:0] r_data,
  output logic        int_req
);

  logic [63:0]           r_mtime;
  logic [63:0]           r_mtimecmp;
  logic                  r_cnt_en;
  logic                  r_irq_en;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_pcnt;
  logic                  r_int_req;

  logic        w_hit;
  logic [2:0]  w_off;
  logic [1:0]  w_lane;
  logic        w_acc_ok;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_al;
  logic [31:0] w_live_word;
  logic [31:0] w_rd_word;
  logic [31:0] w_merged;
  logic [31:0] w_prescale_ext;
  logic        w_wr;
  logic        w_tick;

  function automatic logic [31:0] f_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] word, input logic [2:0] f3,
                                         input logic [1:0] lane);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'h0, sh[15:0]};
      3'b010:  return word;
      default: return 32'h0;
    endcase
  endfunction

  assign w_hit  = (dmem_rw_addr[31:5] == BASE_ADDR[31:5]);
  assign w_off  = dmem_rw_addr[4:2];
  assign w_lane = dmem_rw_addr[1:0];

  // Size decode: byte enables and the store data replicated onto every lane it could target.
  always_comb begin
    w_acc_ok   = 1'b0;
    w_be       = 4'b0000;
    w_wdata_al = dmem_w_data;
    case (funct3)
      3'b000, 3'b100: begin
        w_acc_ok   = 1'b1;
        w_be       = 4'b0001 << w_lane;
        w_wdata_al = {4{dmem_w_data[7:0]}};
      end
      3'b001, 3'b101: begin
        w_acc_ok   = ~w_lane[0];
        w_be       = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata_al = {2{dmem_w_data[15:0]}};
      end
      3'b010: begin
        w_acc_ok = (w_lane == 2'b00);
        w_be     = 4'b1111;
      end
      default: ;
    endcase
  end

  assign w_prescale_ext = 32'(r_prescale);

  always_comb begin
    w_live_word = 32'h0;
    case (w_off)
      3'd0: w_live_word = r_mtime[31:0];
      3'd1: w_live_word = r_mtime[63:32];
      3'd2: w_live_word = r_mtimecmp[31:0];
      3'd3: w_live_word = r_mtimecmp[63:32];
      3'd4: w_live_word = {30'h0, r_irq_en, r_cnt_en};
      3'd5: w_live_word = w_prescale_ext;
      default: w_live_word = 32'h0;
    endcase
  end

  assign w_merged = f_merge(w_live_word, w_wdata_al, w_be);
  assign w_wr     = w_hit && dmem_w_en && w_acc_ok;
  assign w_tick   = r_cnt_en && (r_pcnt == r_prescale);

`ifdef MTIMER_SNAPSHOT_EN
  logic [31:0] r_shadow;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_shadow <= 32'h0;
    else if (w_hit && w_acc_ok && dmem_r_en && (w_off == 3'd0))
      r_shadow <= r_mtime[63:32];
  end

  assign w_rd_word = (w_off == 3'd1) ? r_shadow : w_live_word;
`else
  logic w_unused;
  assign w_unused  = dmem_r_en;
  assign w_rd_word = w_live_word;
`endif

  // A store to either mtime half takes priority over the tick for that cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mtime <= 64'h0;
    end else if (w_wr && (w_off == 3'd0)) begin
      r_mtime[31:0] <= w_merged;
    end else if (w_wr && (w_off == 3'd1)) begin
      r_mtime[63:32] <= w_merged;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_cnt_en   <= 1'b1;
      r_irq_en   <= 1'b0;
      r_prescale <= '0;
    end else if (w_wr) begin
      case (w_off)
        3'd2: r_mtimecmp[31:0]  <= w_merged;
        3'd3: r_mtimecmp[63:32] <= w_merged;
        3'd4: begin
          r_cnt_en <= w_merged[0];
          r_irq_en <= w_merged[1];
        end
        3'd5: r_prescale <= w_merged[PRESCALE_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_pcnt <= '0;
    else if (w_wr && (w_off == 3'd5))
      r_pcnt <= '0;
    else if (r_cnt_en)
      r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_int_req <= 1'b0;
    else
      r_int_req <= r_irq_en && (r_mtime >= r_mtimecmp);
  end

  assign hit     = w_hit;
  assign r_data  = (w_hit && w_acc_ok) ? f_load(w_rd_word, funct3, w_lane) : 32'h0;
  assign int_req = r_int_req;

endmodule

// File: tb/tb_mtimer_responder.sv
// Directed bench for mtimer_responder: register reset values, prescaler, carry, interrupt, lanes, decode.
module tb_mtimer_responder;

  localparam logic [31:0] BASE = 32'h0000_8000;
  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] dmem_rw_addr;
  logic [31:0] dmem_w_data;
  logic        dmem_w_en;
  logic        dmem_r_en;
  logic [2:0]  funct3;
  logic        hit;
  logic [31:0] r_data;
  logic        int_req;

  int errors = 0;
  int checks = 0;

  mtimer_responder #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
    .clock(clock), .reset(reset), .dmem_rw_addr(dmem_rw_addr), .dmem_w_data(dmem_w_data),
    .dmem_w_en(dmem_w_en), .dmem_r_en(dmem_r_en), .funct3(funct3), .hit(hit),
    .r_data(r_data), .int_req(int_req)
  );

  always #5 clock = ~clock;

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    @(negedge clock);
    dmem_rw_addr = a;
    dmem_w_data  = d;
    funct3       = f;
    dmem_w_en    = 1'b1;
    @(posedge clock);
    #1 dmem_w_en = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a, input logic [2:0] f, output logic [31:0] d);
    dmem_rw_addr = a;
    funct3       = f;
    #1 d = r_data;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f, output logic [31:0] d);
    @(negedge clock);
    dmem_rw_addr = a;
    funct3       = f;
    dmem_r_en    = 1'b1;
    #1 d = r_data;
    @(posedge clock);
    #1 dmem_r_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    peek(BASE + 32'h08, F_W, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_cmp_lo got=%h exp=ffffffff", d); end
    peek(BASE + 32'h0C, F_W, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_cmp_hi got=%h exp=ffffffff", d); end
    peek(BASE + 32'h10, F_W, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL rst_ctrl got=%h exp=00000001", d); end
    peek(BASE + 32'h00, F_W, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mtime_lo got=%h exp=0", d); end
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL rst_int_req got=%b exp=0", int_req); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_prescale();
    logic [31:0] d;
    store(BASE + 32'h10, 32'h0, F_W);
    store(BASE + 32'h00, 32'h0, F_W);
    store(BASE + 32'h04, 32'h0, F_W);
    store(BASE + 32'h14, 32'h3, F_W);
    store(BASE + 32'h10, 32'h1, F_W);
    repeat (12) @(posedge clock);
    store(BASE + 32'h10, 32'h0, F_W);
    peek(BASE + 32'h00, F_W, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL presc3_mtime got=%0d exp=3", d); end
    store(BASE + 32'h14, 32'h0, F_W);
    store(BASE + 32'h10, 32'h1, F_W);
    repeat (5) @(posedge clock);
    store(BASE + 32'h10, 32'h0, F_W);
    peek(BASE + 32'h00, F_W, d);
    checks++; if (d !== 32'd9) begin errors++; $display("FAIL presc0_mtime got=%0d exp=9", d); end
  endtask

  task automatic test_carry();
    logic [31:0] d;
    store(BASE + 32'h14, 32'h0, F_W);
    store(BASE + 32'h00, 32'hFFFF_FFFF, F_W);
    store(BASE + 32'h04, 32'h0, F_W);
    store(BASE + 32'h10, 32'h1, F_W);
    store(BASE + 32'h10, 32'h0, F_W);
    peek(BASE + 32'h04, F_W, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL carry_hi got=%h exp=00000001", d); end
    peek(BASE + 32'h00, F_W, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL carry_lo got=%h exp=00000000", d); end
    store(BASE + 32'h00, 32'hFFFF_FFFF, F_W);
    store(BASE + 32'h04, 32'hFFFF_FFFF, F_W);
    store(BASE + 32'h10, 32'h1, F_W);
    store(BASE + 32'h10, 32'h0, F_W);
    peek(BASE + 32'h04, F_W, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap_hi got=%h exp=00000000", d); end
    store(BASE + 32'h04, 32'h7, F_W);
    store(BASE + 32'h10, 32'h1, F_W);
    store(BASE + 32'h00, 32'd100, F_W);
    store(BASE + 32'h10, 32'h0, F_W);
    peek(BASE + 32'h00, F_W, d);
    checks++; if (d !== 32'd101) begin errors++; $display("FAIL store_vs_tick_lo got=%0d exp=101", d); end
    peek(BASE + 32'h04, F_W, d);
    checks++; if (d !== 32'h7) begin errors++; $display("FAIL store_vs_tick_hi got=%h exp=00000007", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    store(BASE + 32'h00, 32'h0, F_W);
    store(BASE + 32'h04, 32'h0, F_W);
    store(BASE + 32'h0C, 32'h0, F_W);
    store(BASE + 32'h08, 32'd20, F_W);
    store(BASE + 32'h10, 32'h3, F_W);
    repeat (20) @(posedge clock);
    #1;
    peek(BASE + 32'h00, F_W, d);
    checks++; if (d !== 32'd20) begin errors++; $display("FAIL irq_mtime got=%0d exp=20", d); end
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL irq_early got=%b exp=0", int_req); end
    @(posedge clock);
    #1;
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL irq_rise got=%b exp=1", int_req); end
    store(BASE + 32'h08, 32'd100, F_W);
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL irq_hold got=%b exp=1", int_req); end
    @(posedge clock);
    #1;
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL irq_fall got=%b exp=0", int_req); end
    store(BASE + 32'h10, 32'h0, F_W);
  endtask

  task automatic test_snapshot();
    logic [31:0] d;
    store(BASE + 32'h14, 32'h0, F_W);
    store(BASE + 32'h00, 32'hFFFF_FFFF, F_W);
    store(BASE + 32'h04, 32'h1, F_W);
    store(BASE + 32'h10, 32'h1, F_W);
    load(BASE + 32'h00, F_W, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL snap_lo got=%h exp=ffffffff", d); end
    load(BASE + 32'h04, F_W, d);
`ifdef MTIMER_SNAPSHOT_EN
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL snap_hi got=%h exp=00000001", d); end
`else
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL snap_hi got=%h exp=00000002", d); end
`endif
    store(BASE + 32'h10, 32'h0, F_W);
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    store(BASE + 32'h0B, 32'h0000_008B, F_B);
    peek(BASE + 32'h08, F_W, d);
    checks++; if (d !== 32'h8B00_0064) begin errors++; $display("FAIL sb_cmp got=%h exp=8b000064", d); end
    peek(BASE + 32'h0A, F_H, d);
    checks++; if (d !== 32'hFFFF_8B00) begin errors++; $display("FAIL lh_cmp got=%h exp=ffff8b00", d); end
    peek(BASE + 32'h0A, F_HU, d);
    checks++; if (d !== 32'h0000_8B00) begin errors++; $display("FAIL lhu_cmp got=%h exp=00008b00", d); end
    store(BASE + 32'h15, 32'h0000_0080, F_B);
    peek(BASE + 32'h15, F_B, d);
    checks++; if (d !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_presc got=%h exp=ffffff80", d); end
    peek(BASE + 32'h15, F_BU, d);
    checks++; if (d !== 32'h0000_0080) begin errors++; $display("FAIL lbu_presc got=%h exp=00000080", d); end
    store(BASE + 32'h11, 32'h0000_0080, F_B);
    peek(BASE + 32'h10, F_W, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL sb_ctrl_hi got=%h exp=00000000", d); end
    store(BASE + 32'h00, 32'h1122_3344, F_W);
    store(BASE + 32'h01, 32'h0000_FFFF, F_H);
    peek(BASE + 32'h00, F_W, d);
    checks++; if (d !== 32'h1122_3344) begin errors++; $display("FAIL sh_misaligned got=%h exp=11223344", d); end
    store(BASE + 32'h02, 32'h0000_BEEF, F_H);
    peek(BASE + 32'h02, F_H, d);
    checks++; if (d !== 32'hFFFF_BEEF) begin errors++; $display("FAIL sh_lh got=%h exp=ffffbeef", d); end
    peek(BASE + 32'h00, F_W, d);
    checks++; if (d !== 32'hBEEF_3344) begin errors++; $display("FAIL sh_word got=%h exp=beef3344", d); end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    store(BASE + 32'h18, 32'hDEAD_BEEF, F_W);
    peek(BASE + 32'h18, F_W, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reserved got=%h exp=0", d); end
    peek(BASE + 32'h02, F_W, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL lw_misaligned got=%h exp=0", d); end
    peek(BASE + 32'h08, 3'b011, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL bad_funct3 got=%h exp=0", d); end
    peek(BASE + 32'h1F, F_B, d);
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_top got=%b exp=1", hit); end
    peek(BASE + 32'h20, F_W, d);
    checks++; if (hit !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL miss_above hit=%b data=%h exp 0/0", hit, d); end
    peek(BASE - 32'h4, F_W, d);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL miss_below got=%b exp=0", hit); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] d;
    store(BASE + 32'h08, 32'h0, F_W);
    store(BASE + 32'h0C, 32'h0, F_W);
    store(BASE + 32'h10, 32'h2, F_W);
    @(posedge clock);
    #1;
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL midop_irq_set got=%b exp=1", int_req); end
    #2 reset = 1'b1;
    #1;
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL midop_irq_clr got=%b exp=0", int_req); end
    peek(BASE + 32'h08, F_W, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL midop_cmp got=%h exp=ffffffff", d); end
    peek(BASE + 32'h10, F_W, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL midop_ctrl got=%h exp=00000001", d); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    dmem_rw_addr = 32'h0;
    dmem_w_data  = 32'h0;
    dmem_w_en    = 1'b0;
    dmem_r_en    = 1'b0;
    funct3       = F_W;
    test_reset();
    test_prescale();
    test_carry();
    test_irq();
    test_snapshot();
    test_byte_lanes();
    test_decode();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
